keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed display driver: scans a 4x4 calculator keypad matrix by driving one active-low column at a time and sensing the active-low rows.
- Debounces the press and the release.
- Emits a 4-bit key code with a one-cycle valid strobe to the calculator control logic.

Parameters:
- CLK_DIV, 1000, clk cycles per scan tick (must be >= 2); all column changes and row samples happen only on ticks.
- DEBOUNCE_TICKS, 8, consecutive stable ticks required to accept a press or a release (must be >= 1).
- REPEAT_TICKS, 200, ticks between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock; the only clock.
- rstn  input  1  reset; synchronous, active-high (asserted = 1), sampled on posedge clk.
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col  output  4  column drive, active-low one-hot: col = 4'b1111 - (1 << col_idx).
- key_code  output  4  {row_idx[1:0], col_idx[1:0]}, i.e. row*4 + col; holds until the next strobe.
- key_valid  output  1  one-clk-cycle strobe; key_code is valid in the same cycle.
- key_held  output  1  high while an accepted key is still pressed (HELD and RELEASE states).

Behaviour:
- Reset (rstn=1 at posedge clk): state=SCAN, col_idx=0, col=4'b1110, key_code=0, key_valid=0, key_held=0, prescaler=0, debounce/repeat counters=0, synchronizer flops=4'b1111. Reset mid-operation aborts any state the same cycle; no strobe is emitted.
- Row input: 2-flop synchronizer; rs = synchronized row. Logic uses rs only.
- Prescaler: counts 0..CLK_DIV-1; tick=1 for one cycle when the count equals CLK_DIV-1, then wraps to 0.
- Press detect: pressed = (rs != 4'hF). prow = index of the lowest-numbered 0 bit in rs (row 0 has priority).
- FSM, evaluated only on tick cycles:
  - SCAN: if pressed, latch prow, freeze col_idx, set cnt=0, go to DEBOUNCE. Otherwise col_idx <= col_idx+1 (wraps 3->0).
  - DEBOUNCE: if rs[latched row]==0 and prow==latched row, cnt++. When cnt reaches DEBOUNCE_TICKS-1, go to HELD and assert key_valid for exactly one clk cycle with key_code={row,col}. If the reading differs, return to SCAN and advance col_idx.
  - HELD: key_held=1. If rs==4'hF, set cnt=0 and go to RELEASE. Otherwise stay.
  - RELEASE: key_held=1. If rs==4'hF, cnt++; at DEBOUNCE_TICKS-1 go to SCAN, clear key_held, advance col_idx. If a press reappears, return to HELD with no new strobe.
- A second key pressed while in HELD/RELEASE is ignored; scanning resumes only after a full release.
- Column is frozen in DEBOUNCE/HELD/RELEASE.
- key_valid is never high on two consecutive clk cycles.
- Minimum press-to-strobe latency: 2 sync cycles + DEBOUNCE_TICKS ticks after the column is reached.

Optional Feature:
- KEYPAD_REPEAT_EN defined: in HELD, a repeat counter counts ticks. The first repeat strobe occurs REPEAT_TICKS ticks after entering HELD, then one every REPEAT_TICKS ticks while the key stays in HELD. key_code is unchanged. The counter is cleared on leaving HELD, and RELEASE->HELD re-entry restarts it.
- Not defined: exactly one key_valid per accepted press; no repeat counter is synthesized and REPEAT_TICKS is unused.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5):
- Reset held 3 cycles, then released with row=4'hF -> col=4'b1110, key_valid=0, key_held=0. col then steps 1101, 1011, 0111, 1110, changing every 4 clks.
- Hold row=4'b1011 whenever col=4'b1101 (key row2, col1) -> col freezes at 1101, a single key_valid pulse with key_code=4'h9, key_held=1. After release: key_held falls 3 ticks later and scanning resumes at col=4'b1011.
- Bounce row=4'b1011 for only 1 tick during DEBOUNCE -> no key_valid, FSM returns to SCAN, col advances.
- Press rows 1 and 3 together on col 2 (row=4'b0101) -> key_code=4'h6, one strobe.
- Release for 1 tick, then press again while in RELEASE -> key_held stays 1, no second strobe. Assert rstn during HELD -> next cycle all outputs at reset values.
- KEYPAD_REPEAT_EN: hold key 4'h0 for 20 ticks -> strobes at HELD entry and at +5, +10, +15 ticks, all key_code=0. Without the macro, one strobe only.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one active-low column per scan tick and debounces presses and releases.
// Emits a one-cycle key_valid strobe with key_code. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);

  if (CLK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("keypad_scanner: CLK_DIV must be >= 2, DEBOUNCE_TICKS and REPEAT_TICKS >= 1");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_sel_q, row_sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      rs;
  logic            tick;
  logic            pressed;
  logic [1:0]      prow;
  logic            cnt_done;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 2) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  assign rs = sync2_q;

  always_comb begin
    sync1_d = row;
    sync2_d = sync1_q;
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Lowest-numbered active row wins when several rows of a column are low.
  always_comb begin
    pressed = (rs != 4'hF);
    casez (rs)
      4'b???0: prow = 2'd0;
      4'b??01: prow = 2'd1;
      4'b?011: prow = 2'd2;
      default: prow = 2'd3;
    endcase
  end

  // The tick that first sees a press or release counts as stable tick one.
  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    cnt_done = (DEBOUNCE_TICKS == 1) || (cnt_inc == CNT_LAST);
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_sel_d   = row_sel_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (pressed) begin
            row_sel_d = prow;
            cnt_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!rs[row_sel_q] && (prow == row_sel_q)) begin
            if (cnt_done) begin
              state_d     = ST_HELD;
              key_valid_d = 1'b1;
              key_code_d  = {row_sel_q, col_idx_q};
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt_q == REP_LAST) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          if (pressed) begin
            state_d = ST_HELD;
          end else if (cnt_done) begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // Repeat period restarts on every entry into HELD, including from RELEASE.
    if ((state_q != ST_HELD) || (state_d != ST_HELD)) begin
      rep_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      presc_q     <= '0;
      col_idx_q   <= 2'd0;
      row_sel_q   <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      presc_q     <= presc_d;
      col_idx_q   <= col_idx_d;
      row_sel_q   <= row_sel_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, randomized presses/bounces and an expected-code queue.
// Timing expectations come from the tick schedule (CLK_DIV cycles per tick, 2-flop sync, DEBOUNCE_TICKS).
module tb_keypad_scanner;

  localparam int CD = 4;
  localparam int DT = 3;
  localparam int RT = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_q[$];
  logic        prev_valid = 1'b0;

  keypad_scanner #(
    .CLK_DIV(CD),
    .DEBOUNCE_TICKS(DT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // Keypad matrix: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cmask(input int c);
    logic [3:0] m;
    m = 4'b1111;
    m[c] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] code_of(input int c, input logic [3:0] rm);
    int lr;
    lr = 0;
    for (int r = 3; r >= 0; r--) if (rm[r]) lr = r;
    return 4'(lr * 4 + c);
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (key_valid) begin
      chk("valid_consecutive", {31'd0, prev_valid}, 32'd0);
      chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
    end
    prev_valid = key_valid;
  end

  // driver tasks
  task automatic set_keys(input int c, input logic [3:0] rm);
    for (int r = 0; r < 4; r++) keys[r*4 + c] = rm[r];
  endtask

  // Presses while the target column is not driven; returns on the first cycle it is.
  task automatic press_keys(input int c, input logic [3:0] rm);
    int n;
    n = 0;
    while (col == cmask(c) && n < 64) begin @(negedge clk); n++; end
    chk("col_leave", {31'd0, n < 64}, 32'd1);
    set_keys(c, rm);
    n = 0;
    while (col != cmask(c) && n < 64) begin @(negedge clk); n++; end
    chk("col_reach", {31'd0, n < 64}, 32'd1);
  endtask

  task automatic accept(input int c, input logic [3:0] rm);
    int n;
    exp_q.push_back(code_of(c, rm));
    press_keys(c, rm);
    n = 0;
    while (!key_valid && n < 100) begin @(negedge clk); n++; end
    chk("press_latency", n, DT * CD);
    chk("held_after_strobe", {31'd0, key_held}, 32'd1);
    chk("col_frozen_held", {28'd0, col}, {28'd0, cmask(c)});
  endtask

  task automatic release_keys(input int c);
    int n;
    keys = '0;
    n = 0;
    while (key_held && n < 100) begin @(negedge clk); n++; end
    chk("release_latency", n, DT * CD);
    chk("col_resume", {28'd0, col}, {28'd0, cmask((c + 1) % 4)});
  endtask

  task automatic bounce(input int c, input logic [3:0] rm);
    press_keys(c, rm);
    repeat (CD) @(negedge clk);
    chk("col_frozen_debounce", {28'd0, col}, {28'd0, cmask(c)});
    keys = '0;
    repeat (CD) @(negedge clk);
    chk("bounce_col_advance", {28'd0, col}, {28'd0, cmask((c + 1) % 4)});
    chk("bounce_not_held", {31'd0, key_held}, 32'd0);
  endtask

  task automatic repress(input int c, input logic [3:0] rm);
    logic held_all;
    accept(c, rm);
    keys = '0;
    held_all = 1'b1;
    repeat (CD) begin @(negedge clk); if (!key_held) held_all = 1'b0; end
    set_keys(c, rm);
    repeat (4 * CD) begin @(negedge clk); if (!key_held) held_all = 1'b0; end
    chk("held_through_repress", {31'd0, held_all}, 32'd1);
    release_keys(c);
  endtask

  task automatic repeat_test();
    int offs[$];
    int expo[$];
    accept(0, 4'b0001);
`ifdef KEYPAD_REPEAT_EN
    for (int m = 1; m * RT * CD < 18 * CD; m++) begin
      exp_q.push_back(4'h0);
      expo.push_back(m * RT * CD);
    end
`endif
    for (int k = 1; k <= 18 * CD; k++) begin
      @(negedge clk);
      if (key_valid) offs.push_back(k);
    end
    chk("repeat_count", offs.size(), expo.size());
    for (int i = 0; i < offs.size() && i < expo.size(); i++) chk("repeat_offset", offs[i], expo[i]);
    release_keys(0);
  endtask

  initial begin
    int c;
    int op;
    logic [3:0] rm;
    rstn = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    chk("rst_col", {28'd0, col}, 32'h0000_000E);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      chk("scan_step", {28'd0, col}, {28'd0, cmask((k / CD) % 4)});
      @(negedge clk);
    end

    accept(1, 4'b0100);
    repeat (CD) @(negedge clk);
    release_keys(1);
    bounce(3, 4'b0100);
    accept(2, 4'b1010);
    release_keys(2);
    repress(1, 4'b0001);

    for (int it = 0; it < 12; it++) begin
      c  = $urandom_range(0, 3);
      rm = 4'($urandom_range(1, 15));
      op = $urandom_range(0, 3);
      if (op == 0) begin
        bounce(c, rm);
      end else begin
        accept(c, rm);
        repeat ($urandom_range(0, 2) * CD) @(negedge clk);
        release_keys(c);
      end
    end

    repeat_test();

    accept(3, 4'b0010);
    repeat (2 * CD) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_col", {28'd0, col}, 32'h0000_000E);
    chk("midrst_valid", {31'd0, key_valid}, 32'd0);
    chk("midrst_held", {31'd0, key_held}, 32'd0);
    chk("midrst_code", {28'd0, key_code}, 32'd0);
    keys = '0;
    rstn = 1'b0;
    repeat (8 * CD) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
